// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the rr_arb_mux channel merger: arbitration mode codes
// and the index-width helper.
package rr_arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_arb_pick.sv
// Combinational request picker: one-hot grant plus binary index.
// Fixed priority is a round-robin search with the start pointer forced to 0.
module rr_arb_mux_arb_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  parameter int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [2*N-1:0]  req_dbl;
  logic [SELW-1:0] eff_ptr;

  // Doubled request vector: scanning from eff_ptr upward covers one full wrap.
  always_comb begin
    eff_ptr = (MODE == ARB_RR) ? ptr : '0;
    req_dbl = {req, req};
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!any && req_dbl[k] && (k >= int'(eff_ptr))) begin
        any             = 1'b1;
        grant[k % N]    = 1'b1;
        idx             = SELW'(k % N);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready merger onto one registered output beat, with
// fixed-priority or round-robin arbitration and the winning index reported.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  logic [N-1:0]    grant;
  logic [SELW-1:0] grant_idx;
  logic            grant_any;
  logic [SELW-1:0] rr_ptr;
  logic [W-1:0]    sel_data;
  logic            load_en;
  logic            capture;

  rr_arb_mux_arb_pick #(
    .N    (N),
    .MODE (MODE),
    .SELW (SELW)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign load_en = !out_valid || out_ready;
  // reset_n gating keeps in_ready low while reset is held, so no source sees a false accept.
  assign in_ready = grant & {N{load_en && reset_n}};
  assign capture  = grant_any && load_en;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      if (MODE == ARB_RR) begin
        rr_ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a round-robin and a fixed-priority instance
// share one stimulus set; expected values are hand-computed constants.
module tb_rr_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   rr_in_ready, fp_in_ready;
  logic           rr_out_valid, fp_out_valid;
  logic [W-1:0]   rr_out_data, fp_out_data;
  logic [1:0]     rr_out_sel, fp_out_sel;

  int n_checks = 0;
  int n_pass   = 0;

  rr_arb_mux #(.W(W), .N(N), .MODE(1)) dut_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.W(W), .N(N), .MODE(0)) dut_fp (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  logic [1:0] exp_seq [5];

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'($urandom);
    in_data   = {$urandom, $urandom, $urandom, $urandom};

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = 4'($urandom) | 4'b0001;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
    end
    check("rst_valid", 64'(rr_out_valid), 64'd0);
    check("rst_data",  64'(rr_out_data),  64'd0);
    check("rst_sel",   64'(rr_out_sel),   64'd0);
    check("rst_ready", 64'(rr_in_ready),  64'd0);
    check("rst_ready_fp", 64'(fp_in_ready), 64'd0);

    reset_n  = 1'b1;
    in_valid = '0;
    step();
    step();
    check("idle_valid", 64'(rr_out_valid), 64'd0);
    check("idle_data",  64'(rr_out_data),  64'd0);
    check("idle_sel",   64'(rr_out_sel),   64'd0);

    // round-robin, all channels valid, one beat per cycle
    do_reset();
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    in_valid = 4'b1111;
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
    exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_valid", 64'(rr_out_valid), 64'd1);
      check("rr_sel",   64'(rr_out_sel),   64'(exp_seq[i]));
      check("rr_data",  64'(rr_out_data),  64'(32'hA0 + 32'(exp_seq[i])));
    end

    // fixed priority with ch1 and ch3 requesting
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_sel",  64'(fp_out_sel),  64'd1);
      check("fp_data", 64'(fp_out_data), 64'hA1);
    end
    in_valid = 4'b1000;
    step();
    check("fp_drop_sel",  64'(fp_out_sel),  64'd3);
    check("fp_drop_data", 64'(fp_out_data), 64'hA3);

    // backpressure
    do_reset();
    set_data(32'h11, 32'hA1, 32'h55, 32'hA3);
    in_valid = 4'b0100;
    step();
    check("bp_cap_sel",  64'(rr_out_sel),  64'd2);
    check("bp_cap_data", 64'(rr_out_data), 64'h55);
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 64'(rr_in_ready), 64'd0);
      step();
      check("bp_valid", 64'(rr_out_valid), 64'd1);
      check("bp_data",  64'(rr_out_data),  64'h55);
      check("bp_sel",   64'(rr_out_sel),   64'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(rr_in_ready), 64'b0001);
    step();
    check("bp_reload_valid", 64'(rr_out_valid), 64'd1);
    check("bp_reload_sel",   64'(rr_out_sel),   64'd0);
    check("bp_reload_data",  64'(rr_out_data),  64'h11);

    // round-robin wrap from rr_ptr=3
    do_reset();
    set_data(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    in_valid = 4'b0100;
    step();
    check("wrap_first_sel", 64'(rr_out_sel), 64'd2);
    in_valid = 4'b0011;
    #1;
    check("wrap_ready0", 64'(rr_in_ready), 64'b0001);
    step();
    check("wrap_sel0",  64'(rr_out_sel),  64'd0);
    check("wrap_data0", 64'(rr_out_data), 64'hC0);
    #1;
    check("wrap_ready1", 64'(rr_in_ready), 64'b0010);
    step();
    check("wrap_sel1",  64'(rr_out_sel),  64'd1);
    check("wrap_data1", 64'(rr_out_data), 64'hC1);
    step();
    check("wrap_sel2", 64'(rr_out_sel), 64'd0);

    // empty: drains and data holds
    in_valid = '0;
    step();
    check("empty_valid", 64'(rr_out_valid), 64'd0);
    check("empty_data",  64'(rr_out_data),  64'hC0);

    // async reset during a stall
    do_reset();
    set_data(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    in_valid = 4'b0010;
    step();
    check("ar_cap_sel", 64'(rr_out_sel), 64'd1);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    step();
    check("ar_stall_valid", 64'(rr_out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(rr_out_valid), 64'd0);
    check("ar_data",  64'(rr_out_data),  64'd0);
    check("ar_sel",   64'(rr_out_sel),   64'd0);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_restart_sel0",  64'(rr_out_sel),  64'd0);
    check("ar_restart_data0", 64'(rr_out_data), 64'hD0);
    step();
    check("ar_restart_sel1",  64'(rr_out_sel),  64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
